pixel_frame_ctrl: RTL and testbench
===================================

Name: pixel_frame_ctrl

Overview:
Frame sequencer for the single-pixel filter datapath (negative-film class: one pixel in, one pixel out, fixed latency, no stall input).
- Reads a frame from a synchronous source pixel memory and drives the filter input.
- Captures filter output into a small elastic buffer and writes it to a destination memory or port that can back-pressure.
- Credit-based issue ensures in-flight pixels are never lost when the destination stalls.

Parameters:
ADDR_W, 16, pixel address width
PIX_W, 24, pixel width (RGB888)
FRAME_PIX, 65536, pixels per frame (1..2**ADDR_W)
MEM_LAT, 1, source read latency in cycles (src_rd to src_data valid)
FILT_LAT, 1, filter latency in cycles (flt_in_valid to flt_valid)
BUF_DEPTH, 4, output buffer depth; must be >= MEM_LAT+FILT_LAT+1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
start  in  1  single-cycle frame start request
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last pixel is written
src_rd  out  1  source read strobe
src_addr  out  ADDR_W  source read address
src_data  in  PIX_W  source pixel, valid MEM_LAT cycles after src_rd
flt_in_valid  out  1  src_rd delayed by MEM_LAT
flt_pixel_in  out  PIX_W  src_data passed through combinationally
flt_valid  in  1  filter output valid
flt_pixel_out  in  PIX_W  filter output pixel
dst_wr  out  1  destination write valid
dst_addr  out  ADDR_W  destination address (0..FRAME_PIX-1, in order)
dst_data  out  PIX_W  destination pixel
dst_ready  in  1  destination accepts when dst_wr&&dst_ready
pix_cnt  out  ADDR_W+1  pixels written this frame
err_overflow  out  1  sticky; flt_valid seen with buffer full

Behaviour:
- Reset (rst=0, async): state IDLE. All outputs 0, all counters and buffer pointers 0, err_overflow 0.
- States:
  - IDLE: on start=1 go to RUN; clear rd_addr, dst_addr, pix_cnt, credits and err_overflow; busy=1 from the next cycle.
  - RUN: src_rd=1 with src_addr=rd_addr when credits < BUF_DEPTH; rd_addr++ per issue. After issuing address FRAME_PIX-1, go to DRAIN.
  - DRAIN: no reads; stay until pix_cnt==FRAME_PIX, then go to DONE.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- start is ignored outside IDLE.
- Credits count pixels issued but not yet written:
  - +1 on src_rd, -1 on a dst handshake; both in the same cycle leaves the count unchanged.
  - Credits never exceed BUF_DEPTH, so the buffer cannot overflow in legal operation.
- Output buffer (FIFO):
  - Push on flt_valid.
  - dst_wr = buffer non-empty, with dst_data from the registered head entry.
  - Pop on dst_wr&&dst_ready; dst_addr++ and pix_cnt++ on each pop.
  - Simultaneous push and pop is allowed, including when full or empty.
  - A push to an empty buffer makes dst_wr visible the next cycle.
- Latency: accepted start at cycle 0 → first src_rd at cycle 1 → first dst_wr at cycle 2+MEM_LAT+FILT_LAT (4 with defaults).
- With dst_ready held at 1, throughput is 1 pixel/cycle and done pulses at cycle FRAME_PIX+MEM_LAT+FILT_LAT+2.
- dst_ready low: dst_wr and dst_data hold stable. Issue stops once credits reach BUF_DEPTH; in-flight pixels still land in the buffer.
- flt_valid while the buffer is full and not popping: err_overflow=1 (sticky until the next accepted start); the pixel is dropped and the pointers do not wrap.
- rst mid-frame: immediate return to IDLE with all state cleared; there is no resume.
- Address wrap: with FRAME_PIX==2**ADDR_W, rd_addr and dst_addr wrap to 0 after the last pixel. pix_cnt is ADDR_W+1 bits wide so it reaches FRAME_PIX without wrapping.

Decomposition:
- Shared package pixel_pkg:
  - typedef pixel_t (logic [PIX_W-1:0]).
  - State enum frame_state_t {IDLE, RUN, DRAIN, DONE}.
  - Default constants PIX_W=24, FRAME_PIX=65536.
- One sub-module: pixel_fifo (parameters DEPTH, W; push/pop/full/empty/head; registered storage, counter-based occupancy).
- Credit counter and FSM live in pixel_frame_ctrl.

Test Plan:
- Reset: rst=0 mid-simulation → all outputs 0 asynchronously, before the next clk edge; busy=0, pix_cnt=0.
- Full-rate frame: FRAME_PIX=16, dst_ready=1, filter model = bitwise invert with latency 1, src_data=addr*0x010101 → 16 dst_wr in consecutive cycles 4..19, dst_data=~(addr*0x010101), done pulse at cycle 20.
- Backpressure: dst_ready low cycles 6–15 → dst_data/dst_addr frozen, src_rd stops after 4 outstanding, no pixel lost or duplicated, err_overflow=0, all 16 outputs in order.
- Start while busy: start pulse at cycle 5 of a running frame → ignored, exactly one done pulse, pix_cnt ends at 16.
- Mid-frame reset: rst=0 at cycle 8, release, new start → frame restarts at addr 0 and completes correctly with no stale dst_wr.
- Overflow check: filter model that injects one extra flt_valid while the buffer is full → err_overflow=1 and stays 1 until the next accepted start.

Source files
------------

// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel type, frame sequencer states and default frame geometry
package pixel_pkg;
   localparam int PIX_W_DEF     = 24;
   localparam int FRAME_PIX_DEF = 65536;
   typedef logic [PIX_W_DEF-1:0] pixel_t;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} frame_state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: small register-file FIFO with counter occupancy; a full FIFO still accepts a push when it pops
module pixel_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_cnt;
   logic          w_push, w_pop;
   assign empty  = r_cnt == '0;
   assign full   = r_cnt == CW'(DEPTH);
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);
   assign head   = empty ? '0 : r_mem[r_rd];
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
         if (w_pop) r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
         r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/pixel_frame_ctrl.sv
// pixel_frame_ctrl: frame sequencer feeding a fixed-latency pixel filter and draining it to a stallable sink
module pixel_frame_ctrl
   import pixel_pkg::*;
#(
   parameter int ADDR_W    = 16,
   parameter int PIX_W     = PIX_W_DEF,
   parameter int FRAME_PIX = FRAME_PIX_DEF,
   parameter int MEM_LAT   = 1,
   parameter int FILT_LAT  = 1,
   parameter int BUF_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              src_rd,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [PIX_W-1:0]  src_data,
   output logic              flt_in_valid,
   output logic [PIX_W-1:0]  flt_pixel_in,
   input  logic              flt_valid,
   input  logic [PIX_W-1:0]  flt_pixel_out,
   output logic              dst_wr,
   output logic [ADDR_W-1:0] dst_addr,
   output logic [PIX_W-1:0]  dst_data,
   input  logic              dst_ready,
   output logic [ADDR_W:0]   pix_cnt,
   output logic              err_overflow
);
   // the buffer must absorb every pixel still in the memory and filter pipes
   localparam int MIN_DEPTH = MEM_LAT + FILT_LAT + 1;
   localparam int DEPTH     = (BUF_DEPTH < MIN_DEPTH) ? MIN_DEPTH : BUF_DEPTH;
   localparam int CW        = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
   localparam logic [ADDR_W:0]   CNT_LAST  = (ADDR_W + 1)'(FRAME_PIX - 1);
   localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FRAME_PIX);
   frame_state_t      r_state, w_next;
   logic [ADDR_W-1:0] r_rd_addr, r_dst_addr;
   logic [ADDR_W:0]   r_pix_cnt;
   logic [CW-1:0]     r_credits;
   logic [MEM_LAT-1:0] r_rd_pipe;
   logic              r_err;
   logic              w_start_ok, w_issue, w_pop, w_full, w_empty, w_last_pop;
   logic [PIX_W-1:0]  w_head;
   assign w_start_ok = (r_state == IDLE) && start;
   assign w_issue    = (r_state == RUN) && (r_credits < CW'(DEPTH));
   assign w_pop      = !w_empty && dst_ready;
   assign w_last_pop = w_pop && (r_pix_cnt == CNT_LAST);
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? RUN : IDLE;
         RUN:     w_next = (w_issue && r_rd_addr == LAST_ADDR) ? DRAIN : RUN;
         DRAIN:   w_next = (w_last_pop || r_pix_cnt == CNT_FULL) ? DONE : DRAIN;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_rd_addr  <= '0;
         r_dst_addr <= '0;
         r_pix_cnt  <= '0;
         r_credits  <= '0;
         r_rd_pipe  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_rd_pipe <= MEM_LAT'({r_rd_pipe, w_issue});
         if (w_start_ok) begin
            r_rd_addr  <= '0;
            r_dst_addr <= '0;
            r_pix_cnt  <= '0;
            r_credits  <= '0;
            r_err      <= 1'b0;
         end else begin
            if (w_issue) r_rd_addr <= r_rd_addr + 1'b1;
            if (w_pop) begin
               r_dst_addr <= r_dst_addr + 1'b1;
               r_pix_cnt  <= r_pix_cnt + 1'b1;
            end
            r_credits <= r_credits + CW'(w_issue) - CW'(w_pop);
            if (flt_valid && w_full && !w_pop) r_err <= 1'b1;
         end
      end
   end
   pixel_fifo #(.DEPTH(DEPTH), .W(PIX_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (flt_valid),
      .pop   (w_pop),
      .din   (flt_pixel_out),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );
   assign busy         = (r_state == RUN) || (r_state == DRAIN);
   assign done         = r_state == DONE;
   assign src_rd       = w_issue;
   assign src_addr     = r_rd_addr;
   assign flt_in_valid = r_rd_pipe[MEM_LAT-1];
   assign flt_pixel_in = flt_in_valid ? src_data : '0;
   assign dst_wr       = !w_empty;
   assign dst_addr     = r_dst_addr;
   assign dst_data     = w_head;
   assign pix_cnt      = r_pix_cnt;
   assign err_overflow = r_err;
endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// tb_pixel_frame_ctrl: directed frames against an inverting one-cycle filter and a one-cycle source memory
module tb_pixel_frame_ctrl;
   import pixel_pkg::*;
   localparam int AW   = 4;
   localparam int NPIX = 16;
   logic clk = 0, rst = 0, start = 0, dst_ready = 1, inject = 0;
   logic busy, done, src_rd, flt_in_valid, flt_valid, dst_wr, err_overflow;
   logic [AW-1:0] src_addr, dst_addr;
   logic [AW:0]   pix_cnt;
   pixel_t src_data, flt_pixel_in, flt_pixel_out, dst_data;
   pixel_t wr_data [64];
   logic [AW-1:0] wr_addr [64];
   int wr_cyc [64];
   int wr_cnt, done_cnt, done_cyc, max_out, hold_bad, rd_cnt;
   logic busy_c1, err_c1, busy_done, err_pre, err_post, err_end;
   logic [AW:0] cnt_end;
   int errors = 0, checks = 0;
   always #5 clk = ~clk;
   always @(posedge clk) begin
      src_data      <= src_rd ? pixel_t'(src_addr) * pixel_t'(24'h010101) : '0;
      flt_valid     <= flt_in_valid | inject;
      flt_pixel_out <= ~flt_pixel_in;
   end
   pixel_frame_ctrl #(.ADDR_W(AW), .PIX_W(24), .FRAME_PIX(NPIX), .MEM_LAT(1), .FILT_LAT(1), .BUF_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
      .flt_in_valid(flt_in_valid), .flt_pixel_in(flt_pixel_in),
      .flt_valid(flt_valid), .flt_pixel_out(flt_pixel_out),
      .dst_wr(dst_wr), .dst_addr(dst_addr), .dst_data(dst_data), .dst_ready(dst_ready),
      .pix_cnt(pix_cnt), .err_overflow(err_overflow)
   );
   // start accepted in cycle 0; each later cycle drives inputs at +1 and samples at +2
   task automatic run_frame(input int lo_from, input int lo_to, input int st_at, input int inj_at, input int ncyc);
      logic prev_stall;
      pixel_t p_data;
      logic [AW-1:0] p_addr;
      for (int i = 0; i < 64; i++) begin
         wr_data[i] = 'x;
         wr_addr[i] = 'x;
         wr_cyc[i]  = -1;
      end
      wr_cnt = 0; done_cnt = 0; done_cyc = -1; max_out = 0; hold_bad = 0; rd_cnt = 0;
      prev_stall = 0; p_data = '0; p_addr = '0;
      busy_c1 = 'x; err_c1 = 'x; busy_done = 'x; err_pre = 'x; err_post = 'x;
      @(posedge clk); #1 start = 1; dst_ready = 1; inject = 0;
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk); #1;
         start     = (c == st_at);
         dst_ready = !(c >= lo_from && c <= lo_to);
         inject    = (c == inj_at);
         #1;
         if (prev_stall && (!dst_wr || dst_data !== p_data || dst_addr !== p_addr)) hold_bad++;
         prev_stall = dst_wr && !dst_ready;
         p_data = dst_data;
         p_addr = dst_addr;
         if (src_rd) rd_cnt++;
         if (dst_wr && dst_ready) begin
            if (wr_cnt < 64) begin
               wr_data[wr_cnt] = dst_data;
               wr_addr[wr_cnt] = dst_addr;
               wr_cyc[wr_cnt]  = c;
            end
            wr_cnt++;
         end
         if (rd_cnt - wr_cnt > max_out) max_out = rd_cnt - wr_cnt;
         if (done) begin
            done_cnt++;
            done_cyc = c;
            busy_done = busy;
         end
         if (c == 1) begin
            busy_c1 = busy;
            err_c1  = err_overflow;
         end
         if (c == inj_at + 1) err_pre = err_overflow;
         if (c == inj_at + 2) err_post = err_overflow;
      end
      start = 0; dst_ready = 1; inject = 0;
      err_end = err_overflow;
      cnt_end = pix_cnt;
   endtask
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #2;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
      checks++; if (src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got=%b exp=0", src_rd); end
      checks++; if (dst_wr !== 1'b0) begin errors++; $display("FAIL reset_dst_wr got=%b exp=0", dst_wr); end
      checks++; if (pix_cnt !== '0) begin errors++; $display("FAIL reset_pix_cnt got=%0d exp=0", pix_cnt); end
      checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_overflow); end
      checks++; if (src_addr !== '0 || dst_addr !== '0) begin errors++; $display("FAIL reset_addr got=%0d/%0d exp=0/0", src_addr, dst_addr); end
      @(posedge clk); #1 rst = 1;
      repeat (2) @(posedge clk);
   endtask
   task automatic test_full_rate();
      pixel_t exp;
      run_frame(-1, -1, -1, -10, 30);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL full_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (done_cyc !== 20) begin errors++; $display("FAIL full_done_cyc got=%0d exp=20", done_cyc); end
      checks++; if (busy_c1 !== 1'b1) begin errors++; $display("FAIL full_busy_c1 got=%b exp=1", busy_c1); end
      checks++; if (busy_done !== 1'b0) begin errors++; $display("FAIL full_busy_at_done got=%b exp=0", busy_done); end
      checks++; if (wr_cnt !== NPIX) begin errors++; $display("FAIL full_wr_cnt got=%0d exp=%0d", wr_cnt, NPIX); end
      checks++; if (cnt_end !== 5'd16) begin errors++; $display("FAIL full_pix_cnt got=%0d exp=16", cnt_end); end
      for (int i = 0; i < NPIX; i++) begin
         exp = ~(pixel_t'(i) * pixel_t'(24'h010101));
         checks++; if (wr_data[i] !== exp) begin errors++; $display("FAIL full_data[%0d] got=%h exp=%h", i, wr_data[i], exp); end
         checks++; if (wr_addr[i] !== AW'(i)) begin errors++; $display("FAIL full_addr[%0d] got=%0d exp=%0d", i, wr_addr[i], i); end
         checks++; if (wr_cyc[i] !== 4 + i) begin errors++; $display("FAIL full_cycle[%0d] got=%0d exp=%0d", i, wr_cyc[i], 4 + i); end
      end
   endtask
   task automatic test_backpressure();
      pixel_t exp;
      run_frame(6, 15, -1, -10, 45);
      checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold got=%0d exp=0", hold_bad); end
      checks++; if (max_out !== 4) begin errors++; $display("FAIL bp_outstanding got=%0d exp=4", max_out); end
      checks++; if (err_end !== 1'b0) begin errors++; $display("FAIL bp_err got=%b exp=0", err_end); end
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (wr_cnt !== NPIX) begin errors++; $display("FAIL bp_wr_cnt got=%0d exp=%0d", wr_cnt, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         exp = ~(pixel_t'(i) * pixel_t'(24'h010101));
         checks++; if (wr_data[i] !== exp || wr_addr[i] !== AW'(i)) begin errors++; $display("FAIL bp_pixel[%0d] got=%h@%0d exp=%h@%0d", i, wr_data[i], wr_addr[i], exp, i); end
      end
   endtask
   task automatic test_start_busy();
      run_frame(-1, -1, 5, -10, 40);
      checks++; if (done_cnt !== 1) begin errors++; $display("FAIL sb_done_cnt got=%0d exp=1", done_cnt); end
      checks++; if (done_cyc !== 20) begin errors++; $display("FAIL sb_done_cyc got=%0d exp=20", done_cyc); end
      checks++; if (cnt_end !== 5'd16) begin errors++; $display("FAIL sb_pix_cnt got=%0d exp=16", cnt_end); end
      checks++; if (wr_cnt !== NPIX) begin errors++; $display("FAIL sb_wr_cnt got=%0d exp=%0d", wr_cnt, NPIX); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sb_busy_after got=%b exp=0", busy); end
   endtask
   task automatic test_mid_reset();
      pixel_t exp;
      @(posedge clk); #1 start = 1; dst_ready = 1;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1 start = 0;
      end
      #1;
      checks++; if (pix_cnt !== 5'd4 || dst_wr !== 1'b1) begin errors++; $display("FAIL mr_pre got=%0d/%b exp=4/1", pix_cnt, dst_wr); end
      rst = 0;
      #1;
      checks++; if (busy !== 1'b0 || src_rd !== 1'b0 || dst_wr !== 1'b0) begin errors++; $display("FAIL mr_async_ctl got=%b%b%b exp=000", busy, src_rd, dst_wr); end
      checks++; if (pix_cnt !== '0 || dst_addr !== '0 || src_addr !== '0) begin errors++; $display("FAIL mr_async_cnt got=%0d/%0d/%0d exp=0/0/0", pix_cnt, dst_addr, src_addr); end
      repeat (2) @(posedge clk);
      #1 rst = 1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #2;
         checks++; if (dst_wr !== 1'b0) begin errors++; $display("FAIL mr_stale_wr[%0d] got=%b exp=0", c, dst_wr); end
      end
      run_frame(-1, -1, -1, -10, 30);
      checks++; if (done_cyc !== 20 || done_cnt !== 1) begin errors++; $display("FAIL mr_done got=%0d/%0d exp=20/1", done_cyc, done_cnt); end
      checks++; if (wr_cnt !== NPIX) begin errors++; $display("FAIL mr_wr_cnt got=%0d exp=%0d", wr_cnt, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         exp = ~(pixel_t'(i) * pixel_t'(24'h010101));
         checks++; if (wr_data[i] !== exp || wr_addr[i] !== AW'(i)) begin errors++; $display("FAIL mr_pixel[%0d] got=%h@%0d exp=%h@%0d", i, wr_data[i], wr_addr[i], exp, i); end
      end
   endtask
   task automatic test_overflow();
      pixel_t exp;
      // four pixels sit in the full buffer from cycle 9; the injected beat lands in cycle 11
      run_frame(6, 15, -1, 10, 45);
      checks++; if (err_pre !== 1'b0) begin errors++; $display("FAIL ov_err_before got=%b exp=0", err_pre); end
      checks++; if (err_post !== 1'b1) begin errors++; $display("FAIL ov_err_after got=%b exp=1", err_post); end
      checks++; if (err_end !== 1'b1) begin errors++; $display("FAIL ov_err_sticky got=%b exp=1", err_end); end
      checks++; if (wr_cnt !== NPIX || done_cnt !== 1) begin errors++; $display("FAIL ov_frame got=%0d/%0d exp=%0d/1", wr_cnt, done_cnt, NPIX); end
      for (int i = 0; i < NPIX; i++) begin
         exp = ~(pixel_t'(i) * pixel_t'(24'h010101));
         checks++; if (wr_data[i] !== exp) begin errors++; $display("FAIL ov_data[%0d] got=%h exp=%h", i, wr_data[i], exp); end
      end
      repeat (3) @(posedge clk);
      #2;
      checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ov_err_idle got=%b exp=1", err_overflow); end
      run_frame(-1, -1, -1, -10, 25);
      checks++; if (err_c1 !== 1'b0) begin errors++; $display("FAIL ov_err_cleared got=%b exp=0", err_c1); end
      checks++; if (done_cyc !== 20 || wr_cnt !== NPIX) begin errors++; $display("FAIL ov_next_frame got=%0d/%0d exp=20/%0d", done_cyc, wr_cnt, NPIX); end
   endtask
   initial begin
      test_reset();
      test_full_rate();
      test_backpressure();
      test_start_busy();
      test_mid_reset();
      test_overflow();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
